// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared types and constants for the RAM burst reader
package ram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // Capture buffer depth; also the read credit limit (buffered + in flight).
  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/ram_burst_reader_fifo2.sv
// rtl/ram_burst_reader_fifo2.sv - 2-entry register FIFO with registered head and count
module fifo2
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [RD_BUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count_q;

  // Callers never push into a full FIFO without popping in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count     = count_q;
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read master for the synchronous RAM, streams words out
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  DATA_DEPTH = 256,
  localparam int AW         = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [AW:0]           cmd_len,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] ADDR_ONE = 1;

  rd_state_t      state_q, state_d;
  logic [AW-1:0]  addr_q;
  logic [AW:0]    issue_cnt_q;
  logic [AW:0]    beat_cnt_q;
  logic           inflight_q;
  logic           cmd_ready_q;
  logic [1:0]     buf_count;
  logic           cmd_fire;
  logic           pop;
  logic           credit;
  logic           issue;

  assign cmd_fire  = cmd_valid && cmd_ready_q;
  assign out_valid = (buf_count != 2'd0);
  assign pop       = out_valid && out_ready;

  // A pop this cycle frees a slot by the time the new word lands.
  assign credit = ((({1'b0, buf_count}) + {2'b00, inflight_q}) < 3'(RD_BUF_DEPTH)) || pop;
  assign issue  = (state_q == ST_ISSUE) && credit;

  assign rd_en     = issue;
  assign rd_addr   = addr_q;
  assign cmd_ready = cmd_ready_q;
  assign out_last  = out_valid && (beat_cnt_q == CNT_ONE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) state_d = (cmd_len == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue && (issue_cnt_q == CNT_ONE)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && (beat_cnt_q == CNT_ONE)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      inflight_q  <= issue;
      if (cmd_fire) begin
        addr_q      <= cmd_addr;
        issue_cnt_q <= cmd_len;
        beat_cnt_q  <= cmd_len;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + ADDR_ONE;
          issue_cnt_q <= issue_cnt_q - CNT_ONE;
        end
        if (pop) beat_cnt_q <= beat_cnt_q - CNT_ONE;
      end
    end
  end

  fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (rd_data),
    .pop       (pop),
    .count     (buf_count),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - self-checking bench for ram_burst_reader with a RAM model
module tb_ram_burst_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] ram [DEPTH];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_burst_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc - 1) % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: out_ready held high with exact cycle timing; 1: 1,0,0 pattern; 2: random.
  task automatic burst(input logic [7:0] addr, input int len, input int mode);
    logic [7:0] exp_q[$];
    int n_rd = 0, beats = 0, cyc = 0, held, limit;
    bit seen_done = 0, pop;
    logic pv = 0, pr = 0, pl = 0;
    logic [7:0] pd = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(8'(addr + i));
    limit = 4 * len + 20;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 9'(len); out_ready = 1'b1;
    #1 check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    while (!seen_done && cyc < limit) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc++;
      out_ready = ready_pat(mode, cyc);
      #1;
      held = n_rd - beats;
      pop  = out_valid && out_ready;
      check("busy", 32'(busy), 32'd1);
      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (mode == 0) begin
        check("rd_en_timing", 32'(rd_en), 32'(cyc <= len));
        check("valid_timing", 32'(out_valid), 32'(cyc >= 3 && cyc <= len + 2));
      end
      if (rd_en) begin
        check("rd_addr", 32'(rd_addr), 32'(8'(addr + n_rd)));
        check("credit", 32'((held < 2) || pop), 32'd1);
        check("rd_overrun", 32'(n_rd < len), 32'd1);
        n_rd++;
      end
      check("buffered_max2", 32'(held <= 2), 32'd1);
      if (pv && !pr) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(pd));
        check("stall_last", 32'(out_last), 32'(pl));
      end
      if (out_valid) begin
        check("extra_beat", 32'(beats < len), 32'd1);
        if (beats < len) begin
          check("out_data", 32'(out_data), 32'(exp_q[beats]));
          check("out_last", 32'(out_last), 32'(beats == len - 1));
        end
      end else begin
        check("last_no_valid", 32'(out_last), 32'd0);
      end
      if (done) begin
        seen_done = 1;
        check("done_beats", 32'(beats), 32'(len));
        if (mode == 0) check("done_cycle", 32'(cyc), 32'((len == 0) ? 1 : len + 3));
      end
      if (pop) beats++;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
    check("done_seen", 32'(seen_done), 32'd1);
    check("beats_total", 32'(beats), 32'(len));
    check("rd_total", 32'(n_rd), 32'(len));
    @(negedge clk);
    #1;
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    #1 check("cmd_ready_reset", 32'(cmd_ready), 32'd1);

    burst(8'h10, 4, 0);
    burst(8'hFE, 4, 0);
    burst(8'h00, 8, 1);
    burst(8'h20, 0, 0);
    burst(8'h80, 256, 0);

    // Reset in cycle 5 of a 10-word burst, then confirm a clean follow-up burst.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 8'h30; cmd_len = 9'd10; out_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
    end
    burst(8'h40, 2, 0);

    for (int k = 0; k < 4; k++) begin
      burst(8'($urandom_range(0, 255)), int'($urandom_range(1, 20)), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
